// File: rtl/phy_reg_free_list_if.sv
`default_nettype none
// ============================================================================
// Module   : phy_reg_free_list_if
// Brief    : Allocation/release bundle between rename/commit and the free list.
// Revision : 1.0 - initial release
// ============================================================================
interface phy_reg_free_list_if #(
   parameter int ENTRY_NUM  = 64,
   parameter int INIT_BASE  = 32,
   parameter int POP_WIDTH  = 2,
   parameter int PUSH_WIDTH = 2
);
   localparam int DEPTH = ENTRY_NUM - INIT_BASE;
   localparam int REG_W = $clog2(ENTRY_NUM);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [POP_WIDTH-1:0]             popReq;
   logic [POP_WIDTH-1:0][REG_W-1:0]  popRegNum;
   logic [PUSH_WIDTH-1:0]            pushReq;
   logic [PUSH_WIDTH-1:0][REG_W-1:0] pushRegNum;
   logic                             ready;
   logic                             allocatable;
   logic [CNT_W-1:0]                 count;
   logic                             errUnderflow;
   logic                             errOverflow;
   logic                             errDoubleFree;

   modport master (
      output popReq, pushReq, pushRegNum,
      input  popRegNum, ready, allocatable, count,
      input  errUnderflow, errOverflow, errDoubleFree
   );

   modport slave (
      input  popReq, pushReq, pushRegNum,
      output popRegNum, ready, allocatable, count,
      output errUnderflow, errOverflow, errDoubleFree
   );
endinterface
`default_nettype wire

// File: rtl/phy_reg_free_list.sv
`default_nettype none
// ============================================================================
// Module   : phy_reg_free_list
// Brief    : Multi-lane circular free list of physical register numbers.
//            Optional double-free bitmap: RSD_FREE_LIST_DOUBLE_FREE_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module phy_reg_free_list #(
   parameter int ENTRY_NUM  = 64,
   parameter int INIT_BASE  = 32,
   parameter int POP_WIDTH  = 2,
   parameter int PUSH_WIDTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   phy_reg_free_list_if.slave     bus
);
   localparam int DEPTH = ENTRY_NUM - INIT_BASE;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int REG_W = $clog2(ENTRY_NUM);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [CNT_W-1:0] c_depth     = DEPTH[CNT_W-1:0];
   localparam logic [CNT_W:0]   c_depth_ext = DEPTH[CNT_W:0];
   localparam logic [CNT_W-1:0] c_pop_w     = POP_WIDTH[CNT_W-1:0];
   localparam logic [REG_W-1:0] c_init_base = INIT_BASE[REG_W-1:0];

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t                           r_state;
   state_t                           w_state_next;
   logic [PTR_W-1:0]                 r_init_idx;
   logic [PTR_W-1:0]                 r_head;
   logic [PTR_W-1:0]                 r_tail;
   logic [CNT_W-1:0]                 r_count;
   logic                             r_alloc;
   logic                             r_err_uf;
   logic                             r_err_of;
   logic [REG_W-1:0]                 r_queue [DEPTH];

   logic                             w_run;
   logic [REG_W-1:0]                 w_init_reg;
   logic [POP_WIDTH-1:0][PTR_W-1:0]  w_pop_addr;
   logic [PUSH_WIDTH-1:0][PTR_W-1:0] w_push_addr;
   logic [PUSH_WIDTH-1:0]            w_push_vld;
   logic [CNT_W-1:0]                 w_pop_cnt;
   logic [CNT_W-1:0]                 w_push_cnt;
   logic [CNT_W:0]                   w_sum;
   logic                             w_pop_ok;
   logic                             w_push_ok;
   logic [CNT_W-1:0]                 w_count_next;

`ifdef RSD_FREE_LIST_DOUBLE_FREE_CHECK_EN
   logic [ENTRY_NUM-1:0]             r_is_free;
   logic                             r_err_df;
   logic                             w_dbl_free;
`endif

   assign w_run      = (r_state == ST_RUN);
   assign w_init_reg = c_init_base + REG_W'(r_init_idx);

   always_comb begin
      w_state_next = r_state;
      if (r_state == ST_INIT && r_init_idx == PTR_W'(DEPTH - 1)) begin
         w_state_next = ST_RUN;
      end
   end

   // Lane offsets are prefix counts of the request masks, so masks need not be compacted.
   always_comb begin
      w_pop_cnt  = '0;
      w_push_cnt = '0;
      w_push_vld = bus.pushReq;
`ifdef RSD_FREE_LIST_DOUBLE_FREE_CHECK_EN
      w_dbl_free = 1'b0;
      for (int j = 0; j < PUSH_WIDTH; j++) begin
         if (r_is_free[bus.pushRegNum[j]]) begin
            w_push_vld[j] = 1'b0;
         end
         for (int k = 0; k < j; k++) begin
            if (bus.pushReq[k] && bus.pushRegNum[k] == bus.pushRegNum[j]) begin
               w_push_vld[j] = 1'b0;
            end
         end
      end
      w_dbl_free = |(bus.pushReq & ~w_push_vld);
`endif
      for (int i = 0; i < POP_WIDTH; i++) begin
         w_pop_addr[i] = r_head + w_pop_cnt[PTR_W-1:0];
         w_pop_cnt     = w_pop_cnt + CNT_W'(bus.popReq[i]);
      end
      for (int j = 0; j < PUSH_WIDTH; j++) begin
         w_push_addr[j] = r_tail + w_push_cnt[PTR_W-1:0];
         w_push_cnt     = w_push_cnt + CNT_W'(w_push_vld[j]);
      end
   end

   // Pops see only the registered count; pushes are judged after accepted pops.
   assign w_pop_ok     = w_run && (w_pop_cnt <= r_count);
   assign w_sum        = {1'b0, r_count} - (w_pop_ok ? {1'b0, w_pop_cnt} : '0)
                         + {1'b0, w_push_cnt};
   assign w_push_ok    = w_run && (w_sum <= c_depth_ext);
   assign w_count_next = r_count - (w_pop_ok ? w_pop_cnt : '0)
                         + (w_push_ok ? w_push_cnt : '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_INIT;
         r_init_idx <= '0;
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
         r_alloc    <= 1'b0;
         r_err_uf   <= 1'b0;
         r_err_of   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (r_state == ST_INIT) begin
            r_init_idx <= r_init_idx + 1'b1;
            if (w_state_next == ST_RUN) begin
               r_count <= c_depth;
               r_alloc <= (c_depth >= c_pop_w);
            end
         end else begin
            if (w_pop_ok) begin
               r_head <= r_head + w_pop_cnt[PTR_W-1:0];
            end else begin
               r_err_uf <= 1'b1;
            end
            if (w_push_ok) begin
               r_tail <= r_tail + w_push_cnt[PTR_W-1:0];
            end else begin
               r_err_of <= 1'b1;
            end
            r_count <= w_count_next;
            r_alloc <= (w_count_next >= c_pop_w);
         end
      end
   end

   // Storage has no reset so it can map onto a RAM; INIT fills it one entry per cycle.
   always_ff @(posedge clk) begin
      if (r_state == ST_INIT) begin
         r_queue[r_init_idx] <= w_init_reg;
      end else if (w_push_ok) begin
         for (int j = 0; j < PUSH_WIDTH; j++) begin
            if (w_push_vld[j]) begin
               r_queue[w_push_addr[j]] <= bus.pushRegNum[j];
            end
         end
      end
   end

`ifdef RSD_FREE_LIST_DOUBLE_FREE_CHECK_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         r_is_free <= '0;
         r_err_df  <= 1'b0;
      end else if (r_state == ST_INIT) begin
         r_is_free[w_init_reg] <= 1'b1;
      end else begin
         if (w_pop_ok) begin
            for (int i = 0; i < POP_WIDTH; i++) begin
               if (bus.popReq[i]) begin
                  r_is_free[r_queue[w_pop_addr[i]]] <= 1'b0;
               end
            end
         end
         if (w_push_ok) begin
            for (int j = 0; j < PUSH_WIDTH; j++) begin
               if (w_push_vld[j]) begin
                  r_is_free[bus.pushRegNum[j]] <= 1'b1;
               end
            end
         end
         if (w_dbl_free) begin
            r_err_df <= 1'b1;
         end
      end
   end
   assign bus.errDoubleFree = r_err_df;
`else
   assign bus.errDoubleFree = 1'b0;
`endif

   generate
      for (genvar i = 0; i < POP_WIDTH; i++) begin : g_pop_out
         assign bus.popRegNum[i] = r_queue[w_pop_addr[i]];
      end
   endgenerate

   assign bus.ready        = w_run;
   assign bus.allocatable  = r_alloc;
   assign bus.count        = r_count;
   assign bus.errUnderflow = r_err_uf;
   assign bus.errOverflow  = r_err_of;

endmodule
`default_nettype wire
